// File: rtl/vgm_wb_arbiter.sv
// vgm_wb_arbiter: round-robin Wishbone bus arbiter with a strobe stall watchdog
module vgm_wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [NUM_MASTERS-1:0]   m_cyc_i,
    input  logic [NUM_MASTERS-1:0]   m_stb_i,
    input  logic [NUM_MASTERS-1:0]   m_we_i,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]   m_ack_o,
    output logic [NUM_MASTERS-1:0]   m_err_o,
    output logic [31:0]              m_dat_o,
    output logic                     CYC_O,
    output logic                     STB_O,
    output logic                     WE_O,
    output logic [31:0]              ADR_O,
    output logic [31:0]              DAT_O,
    input  logic                     ACK_I,
    input  logic [31:0]              DAT_I,
    output logic [NUM_MASTERS-1:0]   grant_o,
    output logic                     timeout_o
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [GW-1:0] g, g_n, last, last_n, pick;
    logic [CW-1:0] cnt, cnt_n;
    logic found, gnt, stall, expire;
    logic [NUM_MASTERS-1:0] own_oh;
    assign m_dat_o = DAT_I;
    assign gnt     = state == GRANT;
    assign own_oh  = NUM_MASTERS'(1) << g;
    assign stall   = gnt & STB_O & ~ACK_I;
    assign expire  = (TIMEOUT > 0) && stall && cnt == CW'(TIMEOUT);
    // first requester found scanning upward from the one after the last owner
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!found && m_cyc_i[(int'(last) + i) % NUM_MASTERS]) begin
                found = 1'b1;
                pick  = GW'((int'(last) + i) % NUM_MASTERS);
            end
        end
    end
    // state, owner, last owner and stall counter registers
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= IDLE;
            g     <= '0;
            last  <= GW'(NUM_MASTERS - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end
    // grant on any request, release when the owner drops CYC, count stall cycles
    always_comb begin
        state_n = state;
        g_n     = g;
        last_n  = last;
        cnt_n   = '0;
        if (state == IDLE) begin
            if (found) begin
                state_n = GRANT;
                g_n     = pick;
            end
        end else if (!m_cyc_i[g]) begin
            state_n = IDLE;
            last_n  = g;
        end else begin
            cnt_n = (TIMEOUT > 0 && stall && !expire) ? cnt + 1'b1 : '0;
        end
    end
    // owner's signals pass straight through; ACK wins over watchdog error
    always_comb begin
        CYC_O     = gnt & m_cyc_i[g];
        STB_O     = gnt & m_stb_i[g];
        WE_O      = gnt & m_we_i[g];
        ADR_O     = gnt ? m_adr_i[32*g +: 32] : '0;
        DAT_O     = gnt ? m_dat_i[32*g +: 32] : '0;
        grant_o   = gnt ? own_oh : '0;
        m_ack_o   = (gnt & ACK_I & m_stb_i[g]) ? own_oh : '0;
        m_err_o   = expire ? own_oh : '0;
        timeout_o = expire;
    end
endmodule

// File: tb/tb_vgm_wb_arbiter.sv
// tb_vgm_wb_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_vgm_wb_arbiter;
    localparam int N = 3;
    localparam int T = 4;
    logic clk = 1'b0;
    logic rst, ack;
    logic [N-1:0] cyc, stb, we;
    logic [32*N-1:0] adr, dat;
    logic [31:0] dati;
    logic [N-1:0] m_ack, m_err, grant;
    logic [31:0] m_dato, adr_o, dat_o;
    logic cyc_o, stb_o, we_o, tmo;
    int checks = 0;
    int fails = 0;
    int own = -1;
    int last = N - 1;
    int run = 0;
    vgm_wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT(T)) dut (
        .CLK_I(clk), .RST_I(rst), .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(adr), .m_dat_i(dat), .m_ack_o(m_ack), .m_err_o(m_err),
        .m_dat_o(m_dato), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o),
        .ADR_O(adr_o), .DAT_O(dat_o), .ACK_I(ack), .DAT_I(dati),
        .grant_o(grant), .timeout_o(tmo)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic stalled();
        return own >= 0 && stb[own] && !ack;
    endfunction
    // expected outputs from the model's owner and the length of the current stall run
    task automatic check_all();
        logic [N-1:0] oh;
        logic e_err;
        oh = (own >= 0) ? N'(1) << own : '0;
        e_err = T > 0 && stalled() && (run + 1) % (T + 1) == 0;
        chk("m_dat_o", m_dato, dati);
        chk("grant", 32'(grant), 32'(oh));
        chk("cyc", 32'(cyc_o), own >= 0 ? 32'(cyc[own]) : 0);
        chk("stb", 32'(stb_o), own >= 0 ? 32'(stb[own]) : 0);
        chk("we", 32'(we_o), own >= 0 ? 32'(we[own]) : 0);
        chk("adr", adr_o, own >= 0 ? adr[32*own +: 32] : 0);
        chk("dat", dat_o, own >= 0 ? dat[32*own +: 32] : 0);
        chk("ack", 32'(m_ack), (own >= 0 && ack && stb[own]) ? 32'(oh) : 0);
        chk("err", 32'(m_err), e_err ? 32'(oh) : 0);
        chk("timeout", 32'(tmo), 32'(e_err));
    endtask
    // advance the model across one rising edge using the inputs the DUT samples
    task automatic model_edge();
        int best;
        if (rst) begin
            own = -1;
            last = N - 1;
            run = 0;
        end else if (own < 0) begin
            best = -1;
            for (int k = 0; k < N; k++)
                if (cyc[k] && (best < 0 || (k - last - 1 + N) % N < (best - last - 1 + N) % N))
                    best = k;
            own = best;
            run = 0;
        end else if (!cyc[own]) begin
            last = own;
            own = -1;
            run = 0;
        end else begin
            run = stalled() ? run + 1 : 0;
        end
    endtask
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask
    initial begin
        rst = 1; ack = 0; cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; dati = 32'h1234_5678;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_cyc", 32'(cyc_o), 0);
        rst = 0;
        // single write from requester 0
        cyc = 3'b001; stb = 3'b001; we = 3'b001; adr[31:0] = 32'h100; dat[31:0] = 32'hCAFE_0001;
        tick();
        chk("t1_cyc", 32'(cyc_o), 1);
        chk("t1_adr", adr_o, 32'h100);
        chk("t1_dat", dat_o, 32'hCAFE_0001);
        chk("t1_grant", 32'(grant), 1);
        tick();
        tick();
        ack = 1; #1;
        chk("t1_ack", 32'(m_ack), 1);
        tick();
        ack = 0; #1;
        chk("t1_ack_off", 32'(m_ack), 0);
        cyc = '0; stb = '0; we = '0;
        tick();
        tick();
        // watchdog on requester 1, then an ACK tying with the second expiry
        cyc = 3'b010; stb = 3'b010;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 9) ack = 1;
            #1;
            chk("wd_tmo", 32'(tmo), (i == 4) ? 1 : 0);
            chk("wd_err", 32'(m_err), (i == 4) ? 32'h2 : 0);
            chk("wd_cyc", 32'(cyc_o), 1);
            if (i == 9) chk("wd_tie_ack", 32'(m_ack), 32'h2);
            tick();
        end
        ack = 0; cyc = '0; stb = '0;
        tick();
        tick();
        // reset in the middle of a grant, then ACK while idle
        cyc = 3'b100; stb = 3'b100;
        tick();
        tick();
        chk("mid_grant", 32'(grant), 32'h4);
        rst = 1;
        tick();
        rst = 0; cyc = 3'b011; stb = 3'b000; ack = 1; #1;
        chk("post_rst_cyc", 32'(cyc_o), 0);
        chk("idle_ack", 32'(m_ack), 0);
        chk("idle_err", 32'(m_err), 0);
        tick();
        ack = 0; #1;
        chk("first_after_rst", 32'(grant), 1);
        cyc = '0;
        tick();
        tick();
        // randomized phase with sticky per-requester CYC/STB
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom % 8 == 0) cyc[k] = ~cyc[k];
                if ($urandom % 4 == 0) stb[k] = ~stb[k];
                if ($urandom % 4 == 0) we[k] = $urandom % 2;
                if ($urandom % 3 == 0) adr[32*k +: 32] = $urandom;
                if ($urandom % 3 == 0) dat[32*k +: 32] = $urandom;
            end
            ack = $urandom % 6 == 0;
            dati = $urandom;
            rst = $urandom % 250 == 0;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
